// File: rtl/ifetch_line_buffer_pkg.sv
// Shared types and constants for the instruction-fetch line buffer.
package ifetch_pkg;

  // Miss-handling controller states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_e;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int TAG_W      = ADDR_W - OFFSET_W;

endpackage

// File: rtl/ifetch_line_buffer_if.sv
// Core-side fetch port, memory fill port and perf counters of the line buffer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The sender holds valid and its payload stable until that edge and
// never waits on ready before raising valid. rsp_valid has no ready: the core
// never stalls, so it is a single-cycle pulse.
interface ifetch_line_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  import ifetch_pkg::*;

  logic              flush;
  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;
  logic              req_ready;
  logic [LINE_W-1:0] rsp_data;
  logic              rsp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [LINE_W-1:0] mem_rsp_data;
  logic              mem_rsp_valid;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
  state_e            dbg_state;

  // Buffer side.
  modport slave (
    input  flush, req_addr, req_valid, mem_req_ready, mem_rsp_data, mem_rsp_valid,
    output req_ready, rsp_data, rsp_valid, mem_req_addr, mem_req_valid,
    output hit_count, miss_count, dbg_state
  );

  // Core plus memory side.
  modport master (
    output flush, req_addr, req_valid, mem_req_ready, mem_rsp_data, mem_rsp_valid,
    input  req_ready, rsp_data, rsp_valid, mem_req_addr, mem_req_valid,
    input  hit_count, miss_count, dbg_state
  );

endinterface

// File: rtl/ifetch_line_buffer_store.sv
// Fully associative tag/valid/data storage with combinational lookup,
// a single write port and a whole-array invalidate.
module ifetch_line_store #(
  parameter int N_LINES   = 4,
  parameter int TAG_BITS  = 28,
  parameter int DATA_BITS = 128,
  parameter int IDX_BITS  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [TAG_BITS-1:0]  lookup_tag_i,
  output logic                 hit_o,
  output logic [DATA_BITS-1:0] hit_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_BITS-1:0]  wr_idx_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [DATA_BITS-1:0] wr_data_i
);

  logic [N_LINES-1:0]   valid_q;
  logic [TAG_BITS-1:0]  tag_q  [N_LINES];
  logic [DATA_BITS-1:0] data_q [N_LINES];

  // Valid bits: flush wins over a same-cycle install so a flushed line never survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload written on install.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Parallel tag compare; tags are unique, so at most one entry matches.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[i];
      end
    end
  end

endmodule

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch line buffer: one-cycle hits from a small fully associative
// line store, single outstanding memory fill on a miss, round-robin victim,
// flush support and hit/miss counters.
module ifetch_line_buffer #(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128
) (
  input  logic                 core_clk_main_800mhz,
  input  logic                 core_reset_async_n,
  ifetch_line_buffer_if.slave  bus
);
  import ifetch_pkg::*;

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LTAG_W = ADDR_W - OFFSET_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   victim_q, victim_d;
  logic               flush_seen_q, flush_seen_d;
  logic [LTAG_W-1:0]  tag_q, tag_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [LINE_W-1:0]  rsp_data_q, rsp_data_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;
  logic               ready_en_q;

  logic               req_ready;
  logic               accept;
  logic [LTAG_W-1:0]  req_tag;
  logic               lookup_hit;
  logic [LINE_W-1:0]  lookup_data;
  logic               wr_en;
  logic               unused_offset;

  // The byte offset within the line does not affect which line is returned.
  assign req_tag       = bus.req_addr[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

  // ready_en_q keeps req_ready low while reset is asserted and for the first edge after.
  assign req_ready = ready_en_q & (state_q == IDLE) & ~bus.flush;
  assign accept    = bus.req_valid & req_ready;

  ifetch_line_store #(
    .N_LINES   (NUM_LINES),
    .TAG_BITS  (LTAG_W),
    .DATA_BITS (LINE_W),
    .IDX_BITS  (IDX_W)
  ) u_store (
    .clk_i        (core_clk_main_800mhz),
    .rst_ni       (core_reset_async_n),
    .flush_i      (bus.flush),
    .lookup_tag_i (req_tag),
    .hit_o        (lookup_hit),
    .hit_data_o   (lookup_data),
    .wr_en_i      (wr_en),
    .wr_idx_i     (victim_q),
    .wr_tag_i     (tag_q),
    .wr_data_i    (bus.mem_rsp_data)
  );

  // State and datapath registers.
  always_ff @(posedge core_clk_main_800mhz or negedge core_reset_async_n) begin
    if (!core_reset_async_n) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      flush_seen_q <= 1'b0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      flush_seen_q <= flush_seen_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Next-state logic: lookup in IDLE, fill request, fill return and install.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    flush_seen_d = flush_seen_q;
    tag_d        = tag_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    wr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        flush_seen_d = 1'b0;
        if (accept) begin
          if (lookup_hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = lookup_data;
            hit_cnt_d   = hit_cnt_q + 32'd1;
          end else begin
            miss_cnt_d = miss_cnt_q + 32'd1;
            tag_d      = req_tag;
            state_d    = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        flush_seen_d = flush_seen_q | bus.flush;
        if (bus.mem_req_ready) begin
          state_d = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        flush_seen_d = flush_seen_q | bus.flush;
        if (bus.mem_rsp_valid) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = bus.mem_rsp_data;
          state_d      = IDLE;
          flush_seen_d = 1'b0;
          // A flush at any point of this miss makes the fill return-only.
          if (!(flush_seen_q | bus.flush)) begin
            wr_en    = 1'b1;
            victim_d = (victim_q == IDX_W'(NUM_LINES - 1)) ? '0 : victim_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.mem_req_valid = (state_q == MISS_REQ);
  assign bus.mem_req_addr  = {tag_q, {OFFSET_W{1'b0}}};
  assign bus.hit_count     = hit_cnt_q;
  assign bus.miss_count    = miss_cnt_q;
  assign bus.dbg_state     = state_q;

endmodule
